// File: rtl/adc_scan_pkg.sv
// adc_scan_pkg: shared state type, channel constants and width helper for the ADC scan sequencer
package adc_scan_pkg;
  typedef enum logic [1:0] {IDLE, CONVERT, GAP} state_t;
  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;
  function automatic int acc_width(input int adc_w, input int avg_log2);
    return adc_w + avg_log2;
  endfunction
endpackage

// File: rtl/adc_avg_acc.sv
// adc_avg_acc: per-channel boxcar accumulator emitting a truncated average every 2^AVG_LOG2 samples
module adc_avg_acc
  import adc_scan_pkg::*;
#(
  parameter int ADC_W    = 13,
  parameter int AVG_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_add,
  input  logic [ADC_W-1:0] i_sample,
  output logic             o_done,
  output logic [ADC_W-1:0] o_avg
);
  localparam int ACC_W = acc_width(ADC_W, AVG_LOG2);
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int N     = 1 << AVG_LOG2;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic [ADC_W-1:0] r_avg;
  logic [ACC_W-1:0] w_sum;
  logic             w_full;
  assign w_sum  = r_acc + ACC_W'(i_sample);
  assign w_full = int'(r_cnt) == N - 1;
  assign o_done = r_done;
  assign o_avg  = r_avg;
  // accumulate samples; the sample completing a window publishes the average and restarts the window
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc  <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
      r_avg  <= '0;
    end else begin
      r_done <= i_add && w_full && !i_clr;
      if (i_clr) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (i_add) begin
        r_acc <= w_full ? '0 : w_sum;
        r_cnt <= w_full ? '0 : r_cnt + CNT_W'(1);
        if (w_full) r_avg <= ADC_W'(w_sum >> AVG_LOG2);
      end
    end
  end
endmodule

// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer: alternates MCP0832 conversions on channels 0/1 and publishes per-channel averages
module adc_scan_sequencer
  import adc_scan_pkg::*;
#(
  parameter int ADC_W          = 13,
  parameter int AVG_LOG2       = 2,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             SCAN_EN,
  output logic             ENABLE,
  output logic             CHANNEL_SELECT,
  input  logic             DONE_RD,
  input  logic [ADC_W-1:0] ADC_VALUE_PORT,
  output logic [ADC_W-1:0] CH0_AVG,
  output logic [ADC_W-1:0] CH1_AVG,
  output logic             AVG_VALID,
  output logic             AVG_CHANNEL,
  output logic             TIMEOUT_ERR
);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  state_t           r_state;
  logic             r_en;
  logic             r_ch;
  logic             r_err;
  logic             r_add;
  logic             r_add_ch;
  logic [ADC_W-1:0] r_sample;
  logic [TO_W-1:0]  r_to;
  logic [GAP_W-1:0] r_gap;
  logic             w_cap;
  logic             w_to;
  logic             w_clr;
  logic             w_done0;
  logic             w_done1;
  assign w_cap          = r_state == CONVERT && r_en && DONE_RD;
  assign w_to           = r_state == CONVERT && r_en && !DONE_RD && r_to == TO_W'(TIMEOUT_CYCLES - 1);
  assign w_clr          = r_state == IDLE;
  assign ENABLE         = r_en;
  assign CHANNEL_SELECT = r_ch;
  assign TIMEOUT_ERR    = r_err;
  assign AVG_VALID      = w_done0 | w_done1;
  assign AVG_CHANNEL    = w_done1;
  // scan FSM: raise ENABLE, wait for DONE_RD or timeout, toggle channel, hold ENABLE low for the gap
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_en     <= 1'b0;
      r_ch     <= CH0;
      r_err    <= 1'b0;
      r_add    <= 1'b0;
      r_add_ch <= CH0;
      r_sample <= '0;
      r_to     <= '0;
      r_gap    <= '0;
    end else begin
      r_add    <= w_cap;
      r_add_ch <= r_ch;
      r_sample <= ADC_VALUE_PORT;
      case (r_state)
        IDLE: if (SCAN_EN) r_state <= CONVERT;
        CONVERT: begin
          if (!r_en) begin
            r_en <= 1'b1;
            r_to <= '0;
          end else if (w_cap || w_to) begin
            r_en    <= 1'b0;
            r_ch    <= ~r_ch;
            r_gap   <= '0;
            r_err   <= r_err | w_to;
            r_state <= GAP;
          end else begin
            r_to <= r_to + TO_W'(1);
          end
        end
        GAP: begin
          if (r_gap == GAP_W'(GAP_CYCLES - 1)) begin
            r_state <= SCAN_EN ? CONVERT : IDLE;
            r_en    <= SCAN_EN;
            r_to    <= '0;
          end else begin
            r_gap <= r_gap + GAP_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  adc_avg_acc #(.ADC_W(ADC_W), .AVG_LOG2(AVG_LOG2)) u_acc0 (
    .clk(clk), .rst(rst), .i_clr(w_clr), .i_add(r_add && r_add_ch == CH0),
    .i_sample(r_sample), .o_done(w_done0), .o_avg(CH0_AVG)
  );
  adc_avg_acc #(.ADC_W(ADC_W), .AVG_LOG2(AVG_LOG2)) u_acc1 (
    .clk(clk), .rst(rst), .i_clr(w_clr), .i_add(r_add && r_add_ch == CH1),
    .i_sample(r_sample), .o_done(w_done1), .o_avg(CH1_AVG)
  );
endmodule
